// File: rtl/fsk_modulator.sv
// fsk_modulator: continuous-phase 16-FSK transmitter producing I/Q samples.
//
// Each accepted 4-bit symbol k is sent as SYMBOL_LEN samples of a tone at
// (k+1) * 1 MHz (FS = 100 MHz). A 32-bit phase accumulator drives a sine
// table that is addressed by the top 8 phase bits. The phase is not reset
// between back-to-back symbols, so the waveform stays continuous. It restarts
// at 0 only after the modulator has returned to IDLE.
//
// Ports:
//   clk          sample clock
//   reset_n      asynchronous active-low reset
//   sym_in       symbol value 0..15
//   sym_valid    sym_in is valid
//   sym_ready    modulator takes sym_in at the next rising edge
//   dac_out_sin  I sample, AMP*sin(phase), signed
//   dac_out_cos  Q sample, AMP*cos(phase), signed
//   out_valid    dac_out_sin/dac_out_cos hold a live sample
//   tx_busy      FSM is in TX (state visibility)
//
// Handshake: a symbol transfers on a rising edge where sym_valid && sym_ready.
// sym_ready is combinational from state only and never depends on sym_valid.
// It is high in IDLE and during the final sample slot of a symbol in TX.
// sym_valid may be held high while sym_ready is low. sym_in is ignored outside
// the transfer edge.
module fsk_modulator #(
  parameter int unsigned SYMBOL_LEN = 100,
  parameter logic [31:0] FTW_STEP   = 32'd42949673
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         sym_in,
  input  logic               sym_valid,
  output logic               sym_ready,
  output logic signed [15:0] dac_out_sin,
  output logic signed [15:0] dac_out_cos,
  output logic               out_valid,
  output logic               tx_busy
);

  // The quarter-wave table below is tabulated for this peak amplitude.
  localparam logic signed [15:0] AMP = 16'sd32000;
  localparam int CNT_W = $clog2(SYMBOL_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_LEN - 1);

  typedef enum logic {IDLE = 1'b0, TX = 1'b1} state_e;

  state_e             state_q;
  logic [31:0]        phase_q;
  logic [31:0]        ftw_q;
  logic [31:0]        ftw_d;
  logic [CNT_W-1:0]   cnt_q;
  logic signed [15:0] sin_q;
  logic signed [15:0] cos_q;
  logic               valid_q;
  logic               at_last;
  logic               accept;
  logic [7:0]         sin_idx;
  logic [7:0]         cos_idx;

  // round(AMP*sin(2*pi*k/256)) for k = 0..64 (first quadrant, inclusive).
  function automatic logic [14:0] quarter_mag(input logic [6:0] k);
    logic [14:0] m;
    case (k)
      7'd0:  m = 15'd0;     7'd1:  m = 15'd785;   7'd2:  m = 15'd1570;  7'd3:  m = 15'd2354;
      7'd4:  m = 15'd3137;  7'd5:  m = 15'd3917;  7'd6:  m = 15'd4695;  7'd7:  m = 15'd5471;
      7'd8:  m = 15'd6243;  7'd9:  m = 15'd7011;  7'd10: m = 15'd7775;  7'd11: m = 15'd8535;
      7'd12: m = 15'd9289;  7'd13: m = 15'd10038; 7'd14: m = 15'd10780; 7'd15: m = 15'd11517;
      7'd16: m = 15'd12246; 7'd17: m = 15'd12968; 7'd18: m = 15'd13682; 7'd19: m = 15'd14388;
      7'd20: m = 15'd15085; 7'd21: m = 15'd15773; 7'd22: m = 15'd16451; 7'd23: m = 15'd17120;
      7'd24: m = 15'd17778; 7'd25: m = 15'd18426; 7'd26: m = 15'd19062; 7'd27: m = 15'd19687;
      7'd28: m = 15'd20301; 7'd29: m = 15'd20902; 7'd30: m = 15'd21490; 7'd31: m = 15'd22065;
      7'd32: m = 15'd22627; 7'd33: m = 15'd23176; 7'd34: m = 15'd23710; 7'd35: m = 15'd24231;
      7'd36: m = 15'd24736; 7'd37: m = 15'd25227; 7'd38: m = 15'd25703; 7'd39: m = 15'd26163;
      7'd40: m = 15'd26607; 7'd41: m = 15'd27035; 7'd42: m = 15'd27447; 7'd43: m = 15'd27843;
      7'd44: m = 15'd28221; 7'd45: m = 15'd28583; 7'd46: m = 15'd28928; 7'd47: m = 15'd29255;
      7'd48: m = 15'd29564; 7'd49: m = 15'd29856; 7'd50: m = 15'd30129; 7'd51: m = 15'd30385;
      7'd52: m = 15'd30622; 7'd53: m = 15'd30841; 7'd54: m = 15'd31041; 7'd55: m = 15'd31222;
      7'd56: m = 15'd31385; 7'd57: m = 15'd31529; 7'd58: m = 15'd31654; 7'd59: m = 15'd31759;
      7'd60: m = 15'd31846; 7'd61: m = 15'd31913; 7'd62: m = 15'd31961; 7'd63: m = 15'd31990;
      default: m = 15'(AMP);  // k == 64, the peak
    endcase
    return m;
  endfunction

  // 256-entry sine table folded from the quarter wave.
  // Quadrants 1 and 3 read the table mirrored (64-k).
  // Quadrants 2 and 3 negate the result.
  function automatic logic signed [15:0] sin_lut(input logic [7:0] idx);
    logic [6:0]  k;
    logic [14:0] m;
    k = idx[6] ? (7'd64 - {1'b0, idx[5:0]}) : {1'b0, idx[5:0]};
    m = quarter_mag(k);
    return idx[7] ? -$signed({1'b0, m}) : $signed({1'b0, m});
  endfunction

  assign at_last   = (cnt_q == CNT_LAST);
  assign sym_ready = reset_n && ((state_q == IDLE) || ((state_q == TX) && at_last));
  assign accept    = sym_valid && sym_ready;
  assign ftw_d     = (32'(sym_in) + 32'd1) * FTW_STEP;
  assign sin_idx   = phase_q[31:24];
  assign cos_idx   = sin_idx + 8'd64;  // cos(x) = sin(x + 90 deg); wraps mod 256

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      ftw_q   <= '0;
      cnt_q   <= '0;
      sin_q   <= '0;
      cos_q   <= '0;
      valid_q <= 1'b0;
    end else if (state_q == IDLE) begin
      valid_q <= 1'b0;
      sin_q   <= '0;
      cos_q   <= '0;
      if (accept) begin
        phase_q <= '0;
        ftw_q   <= ftw_d;
        cnt_q   <= '0;
        state_q <= TX;
      end
    end else begin
      sin_q   <= sin_lut(sin_idx);
      cos_q   <= sin_lut(cos_idx);
      valid_q <= 1'b1;
      // This edge always advances with the current tone. A new tone takes
      // effect from the next sample, so phase stays continuous.
      phase_q <= phase_q + ftw_q;
      if (!at_last) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (accept) begin
        cnt_q <= '0;
        ftw_q <= ftw_d;
      end else begin
        cnt_q   <= '0;
        state_q <= IDLE;
      end
    end
  end

  assign dac_out_sin = sin_q;
  assign dac_out_cos = cos_q;
  assign out_valid   = valid_q;
  assign tx_busy     = (state_q == TX);

endmodule

// File: tb/tb_fsk_modulator.sv
// tb_fsk_modulator: directed-plus-random bench for fsk_modulator.
// Expected samples come from a tone model built with real-valued sine and
// 32-bit phase arithmetic. Handshake and flag expectations follow the
// per-symbol timeline.
module tb_fsk_modulator;

  localparam int          SYM_LEN  = 100;
  localparam logic [31:0] FTW_STEP = 32'd42949673;
  localparam real         PI       = 3.14159265358979323846;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic               sym_valid;
  logic [3:0]         sym_in;
  logic               sym_ready;
  logic signed [15:0] dac_out_sin;
  logic signed [15:0] dac_out_cos;
  logic               out_valid;
  logic               tx_busy;

  int          checks   = 0;
  int          failures = 0;
  logic [3:0]  burst_q[$];
  logic [31:0] exp_q[$];   // {sin, cos} per expected sample
  logic [31:0] ph7;
  int          nb;
  int          gap;

  fsk_modulator dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sym_in      (sym_in),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .dac_out_sin (dac_out_sin),
    .dac_out_cos (dac_out_cos),
    .out_valid   (out_valid),
    .tx_busy     (tx_busy)
  );

  // reference: round(32000*sin(2*pi*idx/256)), half away from zero
  function automatic int ref_lut(input logic [7:0] idx);
    real r;
    r = 32000.0 * $sin(2.0 * PI * real'(idx) / 256.0);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(0.5 - r);
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_sin"},   dac_out_sin, 0);
    check({tag, "_cos"},   dac_out_cos, 0);
    check({tag, "_busy"},  tx_busy, 0);
    check({tag, "_ready"}, sym_ready, 1);
  endtask

  // Sends burst_q back to back, starting in a window where sym_ready is high.
  // With chain=1 the task returns in the window that shows the final sample.
  // The next burst is then accepted on the edge that drops out_valid for one
  // cycle.
  task automatic send_burst(input bit chain);
    logic [31:0] ph;
    logic [31:0] ftw;
    logic [31:0] e;
    int          total;
    int          nsym;
    bit          last;
    bit          bound;
    nsym = burst_q.size();
    exp_q.delete();
    ph = '0;
    foreach (burst_q[i]) begin
      ftw = (32'(burst_q[i]) + 32'd1) * FTW_STEP;
      for (int n = 0; n < SYM_LEN; n++) begin
        exp_q.push_back({16'(ref_lut(ph[31:24])), 16'(ref_lut(ph[31:24] + 8'd64))});
        ph = ph + ftw;
      end
    end
    total = exp_q.size();

    check("ready_pre_accept", sym_ready, 1);
    sym_valid = 1'b1;
    sym_in    = burst_q[0];
    step();
    check("acc_valid", out_valid, 0);
    check("acc_sin",   dac_out_sin, 0);
    check("acc_cos",   dac_out_cos, 0);
    check("acc_busy",  tx_busy, 1);
    check("acc_ready", sym_ready, 0);
    sym_valid = 1'($urandom_range(0, 1));
    sym_in    = 4'($urandom_range(0, 15));

    for (int k = 0; k < total; k++) begin
      step();
      e     = exp_q.pop_front();
      last  = (k == total - 1);
      bound = ((k % SYM_LEN) == SYM_LEN - 2);
      check("smp_valid", out_valid, 1);
      check("smp_sin",   dac_out_sin, $signed(e[31:16]));
      check("smp_cos",   dac_out_cos, $signed(e[15:0]));
      check("smp_ready", sym_ready, (bound || last) ? 1 : 0);
      check("smp_busy",  tx_busy, last ? 0 : 1);
      if (bound && (k / SYM_LEN + 1) < nsym) begin
        sym_valid = 1'b1;
        sym_in    = burst_q[k / SYM_LEN + 1];
      end else if (bound || last) begin
        sym_valid = 1'b0;
        sym_in    = 4'($urandom_range(0, 15));
      end else begin
        sym_valid = 1'($urandom_range(0, 1));
        sym_in    = 4'($urandom_range(0, 15));
      end
    end

    if (!chain) begin
      step();
      check_idle("post_burst");
    end
  endtask

  initial begin
    // reset held with sym_valid asserted
    reset_n   = 1'b0;
    sym_valid = 1'b1;
    sym_in    = 4'd9;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_sin",   dac_out_sin, 0);
    check("rst_cos",   dac_out_cos, 0);
    check("rst_busy",  tx_busy, 0);
    check("rst_ready", sym_ready, 0);
    sym_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check_idle("released");
    repeat (2) begin
      step();
      check("idle_valid", out_valid, 0);
    end

    // single symbols, then a back-to-back pair
    burst_q = '{4'd0};
    send_burst(1'b0);
    burst_q = '{4'd3};
    send_burst(1'b0);
    burst_q = '{4'd0, 4'd1};
    send_burst(1'b0);

    // ten idle cycles, then symbol 5 restarting from phase 0
    repeat (10) begin
      step();
      check_idle("gap10");
    end
    burst_q = '{4'd5};
    send_burst(1'b0);

    // random burst chained straight into symbol 5 (one-cycle drop)
    burst_q.delete();
    burst_q.push_back(4'($urandom_range(0, 15)));
    send_burst(1'b1);
    burst_q = '{4'd5};
    send_burst(1'b0);

    // random bursts with random idle gaps
    for (int r = 0; r < 4; r++) begin
      burst_q.delete();
      nb = $urandom_range(1, 3);
      for (int i = 0; i < nb; i++) burst_q.push_back(4'($urandom_range(0, 15)));
      send_burst(1'b0);
      gap = $urandom_range(0, 6);
      for (int g = 0; g < gap; g++) begin
        step();
        check_idle("rand_gap");
      end
    end

    // reset in the middle of symbol 7, at sample 50
    sym_valid = 1'b1;
    sym_in    = 4'd7;
    step();
    sym_valid = 1'b0;
    repeat (51) step();
    ph7 = 32'd50 * ((32'd7 + 32'd1) * FTW_STEP);
    check("s7_smp50_sin", dac_out_sin, ref_lut(ph7[31:24]));
    check("s7_smp50_cos", dac_out_cos, ref_lut(ph7[31:24] + 8'd64));
    check("s7_busy", tx_busy, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_sin",   dac_out_sin, 0);
    check("midrst_cos",   dac_out_cos, 0);
    check("midrst_busy",  tx_busy, 0);
    check("midrst_ready", sym_ready, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check_idle("post_midrst");
    burst_q = '{4'd2};
    send_burst(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsk_modulator.md
# fsk_modulator

Continuous-phase 16-FSK transmitter producing I/Q baseband samples (sin/cos) at one sample per clock, one 4-bit symbol per SYMBOL_LEN samples. Symbol k maps to tone (k+1)·1 MHz at FS = 100 MHz (1–16 MHz). It is the transmit end of the 16-FSK link and drives the demodulator's adc_in_sin/adc_in_cos inputs directly in loopback benches. The block contains a phase-accumulator NCO, a 256-entry sine LUT and a symbol valid/ready handshake.

## Interface
- SYMBOL_LEN, 100: samples per symbol; equals the demodulator's 100-clock decision window.
- FTW_STEP, 32'd42949673: tuning word for 1 MHz, round(2^32·1e6/1e8).
- AMP, 16'sd32000: peak output amplitude.
- clk  in  1  sample clock (100 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- sym_in  in  4  symbol value 0–15.
- sym_valid  in  1  sym_in valid.
- sym_ready  out  1  block accepts sym_in this cycle.
- dac_out_sin  out  16 signed  I sample, AMP·sin(phase).
- dac_out_cos  out  16 signed  Q sample, AMP·cos(phase).
- out_valid  out  1  samples valid this cycle.
- tx_busy  out  1  state == TX.

## Operation
- States: IDLE, TX. Registers: phase[31:0], ftw[31:0], cnt (0..SYMBOL_LEN-1), state, sample/valid output registers.
- Tuning word: ftw = (sym_in+1)·FTW_STEP, 32-bit unsigned, computed at acceptance.
- LUT: 256 entries, LUT[i] = round(AMP·sin(2πi/256)), signed 16-bit. Sin index = phase[31:24]; cos index = (phase[31:24]+64) mod 256.
- sym_ready = reset_n && (state==IDLE || (state==TX && cnt==SYMBOL_LEN-1)). Combinational; no dependence on sym_valid.
- Accept = sym_valid && sym_ready at a rising edge.
- IDLE edge: out_valid<=0, outputs<=0. On accept: phase<=0, ftw<=new, cnt<=0, state<=TX.
- TX edge: dac_out_sin<=LUT[sin idx], dac_out_cos<=LUT[cos idx], out_valid<=1, phase<=phase+ftw (mod 2^32, wrap silent).
  - cnt<SYMBOL_LEN-1: cnt<=cnt+1.
  - cnt==SYMBOL_LEN-1 with accept: cnt<=0, ftw<=new, state stays TX; phase NOT reset (continuous phase; the add at this edge uses the old ftw).
  - cnt==SYMBOL_LEN-1 without accept: state<=IDLE; phase held.
- sym_in values outside the accept cycle are ignored; sym_valid held without ready is not an error.

## Timing
- Reset (async assert): state=IDLE, phase=0, ftw=0, cnt=0, out_valid=0, dac_out_sin=0, dac_out_cos=0, tx_busy=0, sym_ready=0. Reset mid-symbol aborts immediately; no partial-symbol completion.
- Latency: accept at edge E0 → first sample (phase 0: sin=0, cos=+AMP) registered at E1; out_valid high for exactly SYMBOL_LEN consecutive cycles per symbol.
- Back-to-back symbols: out_valid stays continuously high; no gap cycle; sym_ready high for exactly one cycle per symbol (cnt==SYMBOL_LEN-1).
- No symbol at boundary: out_valid drops one edge after the last TX edge; outputs return to 0; next symbol restarts phase at 0.
- tx_busy is registered state; high from E0+ to the edge ending the last symbol.

## Test plan
- Reset: hold reset_n=0 with sym_valid=1 → all outputs 0, sym_ready=0; release → sym_ready=1, out_valid=0 until accept.
- Symbol 0 alone: out_valid high exactly 100 cycles; sample 0 sin=0 cos=32000; sample 25 (phase 0x40000001, idx 64) sin=32000 cos=0; then out_valid=0, outputs 0.
- Symbol 3 (ftw 171798692): sample 25 phase wraps to 4 → sin=0 cos=32000, confirming 4 MHz period and accumulator wrap.
- Back-to-back 0 then 1 with sym_valid held: out_valid continuous 200 cycles; sym_ready single-cycle pulses; sample 100 phase=4 (sin 0, cos 32000), sample 101 idx 5 (phase continuous, new ftw 85899346).
- sym_valid low at boundary, then symbol 5 ten cycles later: 1-cycle drop of out_valid after sample 99; new symbol's first sample sin=0 cos=32000.
- Reset asserted at sample 50 of symbol 7 → outputs zero in the same cycle; after release symbol 2 transmits 100 samples from phase 0. Loopback into the demodulator for each symbol 0–15 → data_out equals the transmitted symbol.
